// File: rtl/sm83_flags_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sm83_flags_pkg
//  Description : Shared definitions for the SM83 flag bank: architectural
//                flag indices, secondary-carry source encoding and the
//                layout of one saved flag context.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package sm83_flags_pkg;

    // Architectural flag positions inside the flag vector.
    localparam int FLAG_C = 0;
    localparam int FLAG_H = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 3;

    // Secondary carry load source.
    typedef enum logic [1:0] {
        SEC_ALU   = 2'b00,
        SEC_SHIFT = 2'b01,
        SEC_DAA   = 2'b10,
        SEC_RSVD  = 2'b11
    } sec_src_e;

    // Flag count of the classic SM83 layout (Z N H C).
    localparam int CTX_NFLAGS = 4;

    // One saved context for the classic layout: raw primary flags with the
    // secondary carry in the least significant position.  Parametrised
    // instances use the same ordering as a flat vector of NFLAGS+1 bits.
    typedef struct packed {
        logic [CTX_NFLAGS-1:0] pri;
        logic                  sec;
    } flag_ctx_t;

    // Width of a saved context for an arbitrary flag count.
    function automatic int ctx_width(input int nflags);
        return nflags + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sm83_flags_stack.sv
`default_nettype none
// ============================================================================
//  Module      : sm83_flags_stack
//  Description : LIFO of saved flag contexts.  Supports push, pop and a
//                same-cycle push+pop swap with the top entry.  Reports
//                overflow/underflow as single-cycle strobes; the parent
//                keeps the sticky error state.
//  Ports       : clk, rst_n        - clock, async active-low reset
//                push, pop         - stack requests
//                wdata             - context to save (pre-edge registers)
//                rdata             - current top entry (0 when empty)
//                level             - occupied entries
//                full, empty       - level == DEPTH / level == 0
//                restore           - parent must load rdata this cycle
//                overflow          - push while full (push only)
//                underflow         - pop while empty
//  Revision    : 1.0 - initial release
// ============================================================================
module sm83_flags_stack
    import sm83_flags_pkg::*;
#(
    parameter int W     = 5,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty,
    output logic                       restore,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int LW = $clog2(DEPTH + 1);

    logic [LW-1:0] r_level;
    logic [W-1:0]  r_mem [DEPTH];

    logic          w_do_push;
    logic          w_do_pop;
    logic          w_do_swap;
    logic [DEPTH-1:0] w_wr_sel;

    assign empty     = (r_level == '0);
    assign full      = (r_level == LW'(DEPTH));
    assign level     = r_level;

    // A pop (alone or paired with push) is only honoured when not empty;
    // a pop-while-empty also suppresses the paired push.
    assign underflow = pop & empty;
    assign overflow  = push & ~pop & full;
    assign w_do_push = push & ~pop & ~full;
    assign w_do_pop  = pop & ~push & ~empty;
    assign w_do_swap = pop & push & ~empty;
    assign restore   = pop & ~empty;

    // Entry j is written by a push at level j, or by a swap when it is the
    // top entry (level j+1).
    generate
        for (genvar j = 0; j < DEPTH; j++) begin : g_wr_sel
            assign w_wr_sel[j] = (w_do_push & (r_level == LW'(j))) |
                                 (w_do_swap & (r_level == LW'(j + 1)));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
        end else if (w_do_push) begin
            r_level <= r_level + LW'(1);
        end else if (w_do_pop) begin
            r_level <= r_level - LW'(1);
        end
    end

    // Stack contents need no reset: they are unreachable until pushed.
    always_ff @(posedge clk) begin
        for (int j = 0; j < DEPTH; j++) begin
            if (w_wr_sel[j]) begin
                r_mem[j] <= wdata;
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int j = 0; j < DEPTH; j++) begin
            if (r_level == LW'(j + 1)) begin
                rdata = r_mem[j];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sm83_flags_bank.sv
`default_nettype none
// ============================================================================
//  Module      : sm83_flags_bank
//  Description : Parametrised SM83 flag register bank: NFLAGS primary flags
//                with per-flag clear/set/bus/ALU update, a secondary carry,
//                output force/invert, a LIFO of saved contexts and sticky
//                stack/protocol error flags.
//  Ports       : clk, rst_n               - clock, async active-low reset
//                din / dout               - data-bus flag byte in / out
//                src_bus, src_alu         - primary write source select
//                alu_flags                - ALU flag results
//                we, clr, set             - per-flag update enable/modes
//                force_en, cpl            - per-flag output force / invert
//                sec_we, sec_src, sec_sel - secondary carry control
//                shift_out_in, daa_carry_in - secondary carry sources
//                push, pop                - context save / restore
//                err_clr                  - clear sticky errors
//                flags, pri_flags         - effective / raw flags
//                stack_level/full/empty   - stack occupancy
//                stack_err, proto_err     - sticky error flags
//  Revision    : 1.0 - initial release
// ============================================================================
module sm83_flags_bank
    import sm83_flags_pkg::*;
#(
    parameter int NFLAGS   = 4,
    parameter int BUS_W    = 8,
    parameter int FLAG_LSB = 4,
    parameter int DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [BUS_W-1:0]           din,
    output logic [BUS_W-1:0]           dout,
    input  logic                       src_bus,
    input  logic                       src_alu,
    input  logic [NFLAGS-1:0]          alu_flags,
    input  logic [NFLAGS-1:0]          we,
    input  logic [NFLAGS-1:0]          clr,
    input  logic [NFLAGS-1:0]          set,
    input  logic [NFLAGS-1:0]          force_en,
    input  logic [NFLAGS-1:0]          cpl,
    input  logic                       sec_we,
    input  logic [1:0]                 sec_src,
    input  logic                       sec_sel,
    input  logic                       shift_out_in,
    input  logic                       daa_carry_in,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       err_clr,
    output logic [NFLAGS-1:0]          flags,
    output logic [NFLAGS-1:0]          pri_flags,
    output logic [$clog2(DEPTH+1)-1:0] stack_level,
    output logic                       stack_full,
    output logic                       stack_empty,
    output logic                       stack_err,
    output logic                       proto_err
);

    localparam int CW = ctx_width(NFLAGS);

    logic [NFLAGS-1:0] r_pri;
    logic              r_sec;
    logic              r_stack_err;
    logic              r_proto_err;

    logic [NFLAGS-1:0] w_bus_flags;
    logic [NFLAGS-1:0] w_src_val;
    logic              w_src_ok;
    logic [NFLAGS-1:0] w_wr_en;
    logic [NFLAGS-1:0] w_pri_nxt;
    logic              w_sec_nxt;
    logic              w_proto_hit;
    logic [NFLAGS-1:0] w_base;
    logic [CW-1:0]     w_ctx;
    logic [CW-1:0]     w_top;
    logic              w_restore;
    logic              w_overflow;
    logic              w_underflow;
    logic              w_unused_din;

    assign w_bus_flags  = din[FLAG_LSB +: NFLAGS];
    // Bus bits outside the flag field carry no meaning here.
    assign w_unused_din = ^din;

    // Exactly one of src_bus/src_alu must be asserted for a source write.
    assign w_src_ok  = src_bus ^ src_alu;
    assign w_src_val = src_bus ? w_bus_flags : alu_flags;

    // A restore overrides every write; a secondary-carry write also claims
    // the carry slot, so primary C cannot be written in the same cycle.
    generate
        for (genvar i = 0; i < NFLAGS; i++) begin : g_wr_en
            if (i == FLAG_C) begin : g_carry
                assign w_wr_en[i] = we[i] & ~w_restore & ~sec_we;
            end else begin : g_other
                assign w_wr_en[i] = we[i] & ~w_restore;
            end
        end
    endgenerate

    always_comb begin
        w_pri_nxt   = r_pri;
        w_sec_nxt   = r_sec;
        w_proto_hit = 1'b0;
        for (int i = 0; i < NFLAGS; i++) begin
            if (w_wr_en[i]) begin
                if (clr[i]) begin
                    w_pri_nxt[i] = 1'b0;
                end else if (set[i]) begin
                    w_pri_nxt[i] = 1'b1;
                end else if (w_src_ok) begin
                    w_pri_nxt[i] = w_src_val[i];
                end else begin
                    w_proto_hit = 1'b1;
                end
            end
        end
        if (sec_we && !w_restore) begin
            case (sec_src_e'(sec_src))
                SEC_ALU:   w_sec_nxt = alu_flags[FLAG_C];
                SEC_SHIFT: w_sec_nxt = shift_out_in;
                SEC_DAA:   w_sec_nxt = daa_carry_in;
                SEC_RSVD:  w_proto_hit = 1'b1;
                default:   w_proto_hit = 1'b1;
            endcase
        end
    end

    // Saved context is always the raw pre-edge register state.
    assign w_ctx = {r_pri, r_sec};

    sm83_flags_stack #(
        .W     (CW),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
        .wdata     (w_ctx),
        .rdata     (w_top),
        .level     (stack_level),
        .full      (stack_full),
        .empty     (stack_empty),
        .restore   (w_restore),
        .overflow  (w_overflow),
        .underflow (w_underflow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pri <= '0;
            r_sec <= 1'b0;
        end else if (w_restore) begin
            r_pri <= w_top[CW-1:1];
            r_sec <= w_top[0];
        end else begin
            r_pri <= w_pri_nxt;
            r_sec <= w_sec_nxt;
        end
    end

    // Sticky errors: a new error in the same cycle as err_clr wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stack_err <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_stack_err <= w_overflow | w_underflow | (r_stack_err & ~err_clr);
            r_proto_err <= w_proto_hit | (r_proto_err & ~err_clr);
        end
    end

    always_comb begin
        w_base = r_pri;
        if (sec_sel) begin
            w_base[FLAG_C] = r_sec;
        end
    end

    // Force is applied first, then the invert.
    assign flags     = (w_base | force_en) ^ cpl;
    assign pri_flags = r_pri;
    assign stack_err = r_stack_err;
    assign proto_err = r_proto_err;

    always_comb begin
        dout = '0;
        dout[FLAG_LSB +: NFLAGS] = flags;
    end

endmodule
`default_nettype wire

// File: tb/tb_sm83_flags_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sm83_flags_bank
//  Description : Directed self-checking bench for sm83_flags_bank with
//                hand-computed expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sm83_flags_bank;

    logic       clk;
    logic       rst_n;
    logic [7:0] din;
    logic [7:0] dout;
    logic       src_bus;
    logic       src_alu;
    logic [3:0] alu_flags;
    logic [3:0] we;
    logic [3:0] clr;
    logic [3:0] set;
    logic [3:0] force_en;
    logic [3:0] cpl;
    logic       sec_we;
    logic [1:0] sec_src;
    logic       sec_sel;
    logic       shift_out_in;
    logic       daa_carry_in;
    logic       push;
    logic       pop;
    logic       err_clr;
    logic [3:0] flags;
    logic [3:0] pri_flags;
    logic [2:0] stack_level;
    logic       stack_full;
    logic       stack_empty;
    logic       stack_err;
    logic       proto_err;

    int n_checks;
    int n_fail;

    sm83_flags_bank #(
        .NFLAGS   (4),
        .BUS_W    (8),
        .FLAG_LSB (4),
        .DEPTH    (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .din          (din),
        .dout         (dout),
        .src_bus      (src_bus),
        .src_alu      (src_alu),
        .alu_flags    (alu_flags),
        .we           (we),
        .clr          (clr),
        .set          (set),
        .force_en     (force_en),
        .cpl          (cpl),
        .sec_we       (sec_we),
        .sec_src      (sec_src),
        .sec_sel      (sec_sel),
        .shift_out_in (shift_out_in),
        .daa_carry_in (daa_carry_in),
        .push         (push),
        .pop          (pop),
        .err_clr      (err_clr),
        .flags        (flags),
        .pri_flags    (pri_flags),
        .stack_level  (stack_level),
        .stack_full   (stack_full),
        .stack_empty  (stack_empty),
        .stack_err    (stack_err),
        .proto_err    (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        din = '0; src_bus = 0; src_alu = 0; alu_flags = '0;
        we = '0; clr = '0; set = '0; force_en = '0; cpl = '0;
        sec_we = 0; sec_src = 2'b00; sec_sel = 0;
        shift_out_in = 0; daa_carry_in = 0;
        push = 0; pop = 0; err_clr = 0;
    endtask

    task automatic write_alu(input logic [3:0] v);
        we = 4'hF; src_alu = 1; alu_flags = v;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle();
        rst_n = 0;
        repeat (3) tick();

        // Reset state
        check("rst_flags", flags, 4'h0);
        check("rst_dout", dout, 8'h00);
        check("rst_empty", stack_empty, 1'b1);
        check("rst_level", stack_level, 3'd0);
        check("rst_errs", {stack_full, stack_err, proto_err}, 3'b000);
        rst_n = 1;
        tick();

        // ALU write, visible the cycle after the edge
        write_alu(4'hA);
        tick();
        idle();
        check("alu_flags", flags, 4'hA);
        check("alu_dout", dout, 8'hA0);

        // clr beats set beats source for H
        we = 4'b0010; clr = 4'b0010; set = 4'b0010; src_alu = 1; alu_flags = 4'b0010;
        tick();
        idle();
        check("clr_prio", pri_flags, 4'h8);

        // Force then invert: (1000 | 0101) ^ 0100 = 1001
        force_en = 4'b0101; cpl = 4'b0100;
        #1;
        check("force_cpl_flags", flags, 4'h9);
        check("force_cpl_pri", pri_flags, 4'h8);
        check("force_cpl_dout", dout, 8'h90);
        idle();

        // Secondary carry from shift; same-cycle C write (to 1) is blocked
        sec_we = 1; sec_src = 2'b01; shift_out_in = 1;
        we = 4'b0001; src_alu = 1; alu_flags = 4'b0001;
        tick();
        idle();
        check("sec_blocks_c", pri_flags, 4'h8);
        sec_sel = 1;
        #1;
        check("sec_sel1", flags, 4'h9);
        sec_sel = 0;
        #1;
        check("sec_sel0", flags, 4'h8);

        // DAA source, then ALU source
        sec_we = 1; sec_src = 2'b10; daa_carry_in = 0;
        tick();
        idle();
        sec_sel = 1;
        #1;
        check("sec_daa", flags, 4'h8);
        idle();
        sec_we = 1; sec_src = 2'b00; alu_flags = 4'b0001;
        tick();
        idle();
        sec_sel = 1;
        #1;
        check("sec_alu", flags, 4'h9);
        idle();
        sec_we = 1; sec_src = 2'b00; alu_flags = 4'b0000;
        tick();
        idle();

        // Overflow: each push saves the pre-write value while writing k+1
        write_alu(4'h1);
        tick();
        for (int k = 1; k <= 5; k++) begin
            idle();
            write_alu(4'(k + 1));
            push = 1;
            tick();
            check("push_level", stack_level, (k > 4) ? 3'd4 : 3'(k));
            check("push_err", stack_err, (k == 5) ? 1'b1 : 1'b0);
        end
        idle();
        check("push_write_pri", pri_flags, 4'h6);
        check("ovf_full", stack_full, 1'b1);

        // Pops restore 4,3,2,1; same-cycle writes are ignored
        for (int k = 4; k >= 1; k--) begin
            idle();
            pop = 1;
            write_alu(4'hF);
            tick();
            check("pop_pri", pri_flags, 4'(k));
            check("pop_level", stack_level, 3'(k - 1));
        end
        idle();
        check("pop_empty", stack_empty, 1'b1);
        check("pop_err_sticky", stack_err, 1'b1);
        err_clr = 1;
        tick();
        idle();
        check("err_clr_stack", stack_err, 1'b0);
        pop = 1;
        tick();
        idle();
        check("underflow_err", stack_err, 1'b1);
        check("underflow_pri", pri_flags, 4'h1);
        check("underflow_level", stack_level, 3'd0);
        err_clr = 1;
        tick();
        idle();

        // Swap: top=0110, regs=1001, level=1
        write_alu(4'b0110);
        tick();
        idle();
        write_alu(4'b1001);
        push = 1;
        tick();
        idle();
        check("swap_pre_pri", pri_flags, 4'b1001);
        push = 1; pop = 1;
        write_alu(4'hF);
        tick();
        idle();
        check("swap_pri", pri_flags, 4'b0110);
        check("swap_level", stack_level, 3'd1);
        check("swap_err", stack_err, 1'b0);
        pop = 1;
        tick();
        idle();
        check("swap_top", pri_flags, 4'b1001);
        check("swap_done_level", stack_level, 3'd0);

        // Protocol error: both sources selected, Z must hold
        we = 4'b1000; src_bus = 1; src_alu = 1; din = 8'h00;
        tick();
        idle();
        check("proto_set", proto_err, 1'b1);
        check("proto_hold", pri_flags, 4'b1001);
        err_clr = 1;
        tick();
        idle();
        check("proto_clr", proto_err, 1'b0);

        // Bus source write of Z=0 and H=1 via din
        we = 4'b1010; src_bus = 1; din = 8'h20;
        tick();
        idle();
        check("bus_write", pri_flags, 4'b0011);

        // Reserved secondary source holds sec and flags an error, even
        // when err_clr is asserted in the same cycle
        sec_we = 1; sec_src = 2'b11; alu_flags = 4'h1; err_clr = 1;
        tick();
        idle();
        check("rsvd_err", proto_err, 1'b1);
        sec_sel = 1;
        #1;
        check("rsvd_hold", flags, 4'b0010);
        idle();

        // Async reset mid-push
        write_alu(4'h7);
        push = 1;
        tick();
        check("pre_rst_level", stack_level, 3'd1);
        write_alu(4'h5);
        push = 1;
        #2;
        rst_n = 0;
        #1;
        check("arst_pri", pri_flags, 4'h0);
        check("arst_level", stack_level, 3'd0);
        check("arst_empty", stack_empty, 1'b1);
        check("arst_errs", {stack_err, proto_err}, 2'b00);
        check("arst_dout", dout, 8'h00);
        idle();
        tick();
        rst_n = 1;
        tick();
        check("post_rst_pri", pri_flags, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
